// File: rtl/mips_cpu_lsu.sv
// Load/store unit between the multicycle MIPS core and an Avalon-MM bus: byte/half/word
// lanes, extension, waitrequest timeout. Define MIPS_LSU_UNALIGNED_LWLR_EN to enable LWL/LWR.
module mips_cpu_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           req_rt_old,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [31:0]           writedata,
    output logic [3:0]            byteenable,
    input  logic [31:0]           readdata
);
    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // req_ready is high only in IDLE, and the response is a single resp_valid pulse.
    typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} state_t;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
`ifdef MIPS_LSU_UNALIGNED_LWLR_EN
    localparam logic [3:0] OP_LWL = 4'd8;
    localparam logic [3:0] OP_LWR = 4'd9;
`endif

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t           state;
    logic [3:0]       opQ;
    logic [1:0]       kQ;
    logic [CNT_W-1:0] waitCnt;
    logic [31:0]      rtOldQ;

    logic        isLoad, isStore, legalOp, aligned;
    logic [3:0]  beNext;
    logic [31:0] wdNext;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadResult;
    logic        timeoutHit;

`ifndef MIPS_LSU_UNALIGNED_LWLR_EN
    logic unusedRtOld;
    assign unusedRtOld = ^rtOldQ;
`endif

    always_comb begin
        isLoad  = 1'b0;
        isStore = 1'b0;
        legalOp = 1'b1;
        aligned = 1'b1;
        beNext  = 4'b1111;
        wdNext  = 32'h0;
        case (req_op)
            OP_LB, OP_LBU: isLoad = 1'b1;
            OP_LH, OP_LHU: begin
                isLoad  = 1'b1;
                aligned = ~req_addr[0];
            end
            OP_LW: begin
                isLoad  = 1'b1;
                aligned = (req_addr[1:0] == 2'b00);
            end
            OP_SB: begin
                isStore = 1'b1;
                beNext  = 4'b0001 << req_addr[1:0];
                wdNext  = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            end
            OP_SH: begin
                isStore = 1'b1;
                aligned = ~req_addr[0];
                beNext  = req_addr[1] ? 4'b1100 : 4'b0011;
                wdNext  = req_addr[1] ? {req_wdata[15:0], 16'h0} : {16'h0, req_wdata[15:0]};
            end
            OP_SW: begin
                isStore = 1'b1;
                aligned = (req_addr[1:0] == 2'b00);
                wdNext  = req_wdata;
            end
`ifdef MIPS_LSU_UNALIGNED_LWLR_EN
            OP_LWL, OP_LWR: isLoad = 1'b1;
`endif
            default: legalOp = 1'b0;
        endcase
    end

    // Lane extraction and extension/merge of the word returned by the bus.
    always_comb begin
        laneByte   = readdata[{kQ, 3'b000} +: 8];
        laneHalf   = kQ[1] ? readdata[31:16] : readdata[15:0];
        loadResult = readdata;
        case (opQ)
            OP_LB:  loadResult = {{24{laneByte[7]}}, laneByte};
            OP_LBU: loadResult = {24'h0, laneByte};
            OP_LH:  loadResult = {{16{laneHalf[15]}}, laneHalf};
            OP_LHU: loadResult = {16'h0, laneHalf};
`ifdef MIPS_LSU_UNALIGNED_LWLR_EN
            OP_LWL: begin
                case (kQ)
                    2'd0:    loadResult = {readdata[7:0], rtOldQ[23:0]};
                    2'd1:    loadResult = {readdata[15:0], rtOldQ[15:0]};
                    2'd2:    loadResult = {readdata[23:0], rtOldQ[7:0]};
                    default: loadResult = readdata;
                endcase
            end
            OP_LWR: begin
                case (kQ)
                    2'd0:    loadResult = readdata;
                    2'd1:    loadResult = {rtOldQ[31:24], readdata[31:8]};
                    2'd2:    loadResult = {rtOldQ[31:16], readdata[31:16]};
                    default: loadResult = {rtOldQ[31:8], readdata[31:24]};
                endcase
            end
`endif
            default: loadResult = readdata;
        endcase
    end

    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= 32'h0;
            byteenable <= 4'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_error <= 1'b0;
            opQ        <= 4'h0;
            kQ         <= 2'b00;
            waitCnt    <= '0;
            rtOldQ     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (!legalOp || !aligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state      <= BUS;
                            address    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            read       <= isLoad;
                            write      <= isStore;
                            writedata  <= wdNext;
                            byteenable <= beNext;
                            opQ        <= req_op;
                            kQ         <= req_addr[1:0];
                            rtOldQ     <= req_rt_old;
                            waitCnt    <= '0;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (read) begin
                            state <= RDATA;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b0;
                            resp_rdata <= 32'h0;
                        end
                    end else if (timeoutHit) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                RDATA: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= loadResult;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed bench for mips_cpu_lsu: a transaction-level model predicts the bus activity,
// response timing and result of every request, checked each cycle on the falling edge.
module tb_mips_cpu_lsu;
  localparam int AW = 32;
  localparam int TO = 4;
`ifdef MIPS_LSU_UNALIGNED_LWLR_EN
  localparam bit LWLR_EN = 1'b1;
`else
  localparam bit LWLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = 4'h0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic [31:0]   req_rt_old = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic          waitrequest;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic [31:0]   readdata;

  mips_cpu_lsu #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  bit          chk_en = 1'b0;
  bit          tx_active = 1'b0;
  int          acc_cyc, n_bus, resp_off, stall_target;
  bit          exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wd, tx_mem;
  logic [3:0]  exp_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // transaction-level model of one request
  task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rt, input logic [31:0] mem, input int stall,
                       output bit err, output logic [31:0] rdata, output bit rd, output bit wr,
                       output logic [3:0] be, output logic [31:0] wd, output int nbus,
                       output int roff);
    logic [7:0] mb[4];
    int k, v;
    bit legal, al;
    for (int i = 0; i < 4; i++) mb[i] = mem[8*i +: 8];
    k = int'(addr[1:0]);
    legal = (op <= 4'd7) || (LWLR_EN && (op == 4'd8 || op == 4'd9));
    if (op == 4'd2 || op == 4'd3 || op == 4'd6) al = (k % 2 == 0);
    else if (op == 4'd4 || op == 4'd7) al = (k == 0);
    else al = 1'b1;
    rdata = 32'h0; rd = 0; wr = 0; be = 4'hF; wd = 32'h0; err = 0; nbus = 0; roff = 1;
    if (!legal || !al) begin
      err = 1;
      return;
    end
    rd = !(op >= 4'd5 && op <= 4'd7);
    wr = !rd;
    if (op == 4'd5) be = 4'(1 << k);
    else if (op == 4'd6) be = (k >= 2) ? 4'b1100 : 4'b0011;
    for (int i = 0; i < 4; i++) begin
      if (op == 4'd5) wd[8*i +: 8] = be[i] ? wdata[7:0] : 8'h0;
      else if (op == 4'd6) wd[8*i +: 8] = be[i] ? wdata[8*(i%2) +: 8] : 8'h0;
      else if (op == 4'd7) wd[8*i +: 8] = wdata[8*i +: 8];
    end
    if (TO > 0 && stall >= TO) begin
      err = 1; nbus = TO; roff = TO + 1;
      return;
    end
    nbus = stall + 1;
    roff = rd ? nbus + 2 : nbus + 1;
    case (op)
      4'd0: begin v = int'(mb[k]); if (v > 127) v -= 256; rdata = 32'(v); end
      4'd1: rdata = 32'(int'(mb[k]));
      4'd2: begin v = int'({mb[k+1], mb[k]}); if (v > 32767) v -= 65536; rdata = 32'(v); end
      4'd3: rdata = 32'(int'({mb[k+1], mb[k]}));
      4'd4: rdata = mem;
      4'd8: for (int j = 0; j < 4; j++) rdata[8*j +: 8] = (j >= 3 - k) ? mb[j-(3-k)] : rt[8*j +: 8];
      4'd9: for (int j = 0; j < 4; j++) rdata[8*j +: 8] = (j <= 3 - k) ? mb[j+k] : rt[8*j +: 8];
      default: rdata = 32'h0;
    endcase
  endtask

  // Avalon slave: programmable stall count, readdata valid only the cycle after acceptance
  initial begin
    bit pending;
    int stall_cnt;
    pending = 0; stall_cnt = 0;
    waitrequest = 1'b0;
    readdata = 32'h5A5A5A5A;
    forever begin
      @(negedge clk);
      readdata = pending ? tx_mem : 32'h5A5A5A5A;
      if (read || write) begin
        if (stall_cnt < stall_target) begin
          waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          waitrequest = 1'b0;
        end
      end else begin
        waitrequest = 1'b0;
        stall_cnt = 0;
      end
      pending = read && !waitrequest;
    end
  end

  // scoreboard / compare process
  initial begin
    int off;
    bit bus_on;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (tx_active) begin
        off = cyc - acc_cyc;
        if (off >= 1) begin
          bus_on = (off <= n_bus);
          check("read", read, exp_rd && bus_on);
          check("write", write, exp_wr && bus_on);
          if (bus_on) begin
            check("address", address, exp_addr);
            check("byteenable", byteenable, exp_be);
            if (exp_wr) check("writedata", writedata, exp_wd);
          end
          check("resp_valid", resp_valid, off == resp_off);
          if (resp_valid) begin
            if (exp_q.size() == 0) begin
              check("resp_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("resp_rdata", resp_rdata, e[31:0]);
              check("resp_error", resp_error, e[32]);
            end
          end
          check("req_ready", req_ready, off > resp_off);
          if (off > resp_off) tx_active = 1'b0;
        end
      end else if (chk_en) begin
        check("idle_resp_valid", resp_valid, 0);
      end
    end
  end

  // driver tasks
  task automatic start_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rt, input logic [31:0] mem, input int stall,
                           output logic [31:0] mr);
    int w;
    bit err;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", req_ready, 1);
    model(op, addr, wdata, rt, mem, stall, err, mr, exp_rd, exp_wr, exp_be, exp_wd, n_bus, resp_off);
    exp_addr = {addr[31:2], 2'b00};
    exp_q.push_back({err, mr});
    stall_target = stall;
    tx_mem = mem;
    req_op = op; req_addr = addr; req_wdata = wdata; req_rt_old = rt;
    req_valid = 1'b1;
    acc_cyc = cyc;
    tx_active = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_rt_old = $urandom;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (tx_active && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (tx_active) begin
      check("resp_timeout", 0, 1);
      tx_active = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rt, input logic [31:0] mem, input int stall,
                     input logic [31:0] lit);
    logic [31:0] mr;
    start_req(op, addr, wdata, rt, mem, stall, mr);
    check("model_pin", mr, lit);
    wait_done();
  endtask

  initial begin
    logic [31:0] mr;
    stall_target = 0;
    tx_mem = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_address", address, 0);
    check("rst_writedata", writedata, 0);
    check("rst_byteenable", byteenable, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_error", resp_error, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    run(4'd4, 32'h1000, 32'h0, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    run(4'd0, 32'h1003, 32'h0, 32'h0, 32'h80FF0000, 0, 32'hFFFFFF80);
    run(4'd1, 32'h1003, 32'h0, 32'h0, 32'h80FF0000, 0, 32'h00000080);
    start_req(4'd6, 32'h2002, 32'h1234ABCD, 32'h0, 32'h0, 3, mr);
    check("pin_sh_wd", exp_wd, 32'hABCD0000);
    check("pin_sh_be", exp_be, 4'b1100);
    wait_done();
    run(4'd4, 32'h1001, 32'h0, 32'h0, 32'h11111111, 0, 32'h0);
    run(4'd2, 32'h1001, 32'h0, 32'h0, 32'h11111111, 0, 32'h0);
    run(4'd4, 32'h1004, 32'h0, 32'h0, 32'h12345678, 100, 32'h0);
    run(4'd4, 32'h1004, 32'h0, 32'h0, 32'h12345678, 3, 32'h12345678);
    run(4'd4, 32'h1004, 32'h0, 32'h0, 32'h12345678, 4, 32'h0);
    run(4'd2, 32'h1006, 32'h0, 32'h0, 32'h80011234, 0, 32'hFFFF8001);
    run(4'd3, 32'h1006, 32'h0, 32'h0, 32'h80011234, 0, 32'h00008001);
    run(4'd2, 32'h1004, 32'h0, 32'h0, 32'h80011234, 1, 32'h00001234);
    run(4'd0, 32'h1001, 32'h0, 32'h0, 32'h00007F00, 0, 32'h0000007F);
    start_req(4'd5, 32'h1001, 32'hAAAAAA77, 32'h0, 32'h0, 0, mr);
    check("pin_sb_wd", exp_wd, 32'h00007700);
    check("pin_sb_be", exp_be, 4'b0010);
    wait_done();
    run(4'd5, 32'h1003, 32'h000000C3, 32'h0, 32'h0, 2, 32'h0);
    run(4'd7, 32'h1008, 32'hCAFEBABE, 32'h0, 32'h0, 1, 32'h0);
    run(4'd6, 32'h1001, 32'h12345678, 32'h0, 32'h0, 0, 32'h0);
    run(4'd7, 32'h100A, 32'h12345678, 32'h0, 32'h0, 0, 32'h0);
    run(4'd10, 32'h1000, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    run(4'd15, 32'h1000, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    run(4'd8, 32'h1001, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, LWLR_EN ? 32'h2211CCDD : 32'h0);
    run(4'd9, 32'h1001, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, LWLR_EN ? 32'hAA443322 : 32'h0);
    run(4'd8, 32'h1003, 32'h0, 32'hAABBCCDD, 32'h44332211, 1, LWLR_EN ? 32'h44332211 : 32'h0);
    run(4'd9, 32'h1000, 32'h0, 32'hAABBCCDD, 32'h44332211, 0, LWLR_EN ? 32'h44332211 : 32'h0);

    // reset while stalled in BUS: response dropped, bus released, ready again
    start_req(4'd4, 32'h3000, 32'h0, 32'h0, 32'h55555555, 100, mr);
    @(negedge clk);
    reset = 1'b1;
    tx_active = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_read", read, 0);
    check("rst_mid_write", write, 0);
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_resp_valid", resp_valid, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_read", read, 0);
    run(4'd4, 32'h3004, 32'h0, 32'h0, 32'h0BADF00D, 0, 32'h0BADF00D);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
